ha_result_packer: RTL

- Downstream consumer of the half-adder behavioural stage, which produces a carry bit (a&b) and a sum bit (a^b) per evaluation.
- Collects PAIRS successive {carry,sum} results over a valid/ready input handshake and packs them into one frame word.
- Keeps a saturating running total of the 2-bit values in the frame.
- Presents the frame through a single-entry output buffer with valid/ready handshake to the next stage (monitor or checker).

---
 rtl/ha_result_packer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ha_result_packer.sv
// Packs PAIRS successive half-adder {carry,sum} results into one frame word with a saturating total.
// Optional build macro HA_RESULT_CHECK_EN flags the impossible (1,1) pair on out_err.
//
// state   | meaning
// IDLE    | empty frame, waiting for the first pair
// COLLECT | at least one pair held, frame not yet complete
// HOLD    | frame complete, presented on the output until out_ready
module ha_result_packer #(
   parameter int PAIRS = 4,
   parameter int ACC_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_carry,
   input  logic                 in_sum,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*PAIRS-1:0]   out_frame,
   output logic [ACC_W-1:0]     out_total,
   output logic                 out_ovf,
   output logic                 out_err,
   output logic                 busy
);

   localparam int IDX_W = $clog2(PAIRS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAIRS - 1);
   localparam logic [ACC_W-1:0] TOTAL_MAX = '1;

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [2*PAIRS-1:0]   frame_q, frame_d;
   logic [ACC_W-1:0]     total_q, total_d;
   logic                 ovf_q, ovf_d;
   logic [1:0]           pair;
   logic                 accept;
   logic                 release_frame;
   logic [ACC_W:0]       sum_ext;

   assign in_ready      = (state_q != HOLD);
   assign busy          = (state_q == COLLECT);
   assign out_valid     = (state_q == HOLD);
   assign out_frame     = frame_q;
   assign out_total     = total_q;
   assign out_ovf       = ovf_q;

   assign pair          = {in_carry, in_sum};
   assign accept        = in_valid && in_ready;
   assign release_frame = out_valid && out_ready;
   // one extra bit catches the carry-out that triggers saturation
   assign sum_ext       = {1'b0, total_q} + {{(ACC_W-1){1'b0}}, pair};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      total_d = total_q;
      ovf_d   = ovf_q;

      if (accept) begin
         for (int k = 0; k < PAIRS; k++) begin
            if (idx_q == IDX_W'(k)) frame_d[2*k +: 2] = pair;
         end
         if (sum_ext[ACC_W]) begin
            total_d = TOTAL_MAX;
            ovf_d   = 1'b1;
         end else begin
            total_d = sum_ext[ACC_W-1:0];
         end
         idx_d = idx_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (accept) state_d = COLLECT;
         end
         COLLECT: begin
            if (accept && (idx_q == LAST_IDX)) state_d = HOLD;
         end
         HOLD: begin
            if (release_frame) begin
               state_d = IDLE;
               idx_d   = '0;
               frame_d = '0;
               total_d = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         frame_q <= '0;
         total_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         total_q <= total_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef HA_RESULT_CHECK_EN
   // a half adder can never assert carry and sum together
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (accept && in_carry && in_sum) err_d = 1'b1;
      if (release_frame) err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule
